// File: rtl/cnn_fc_sequencer.sv
// cnn_fc_sequencer: frame controller for the conv feature extractor + FC pipeline.
// Sequence per frame: flush FC, run PEs, count features, drain FC words, hold result.
// Ports: clk, rst_n (sync, active low), start, abort, pe_enable, fc_enable,
//   fc_pipe_reset, conv_valid, fc_out_valid, fc_out_data, fc_out_ready,
//   result_data, result_valid, result_ack, busy, error, frame_count.
// Optional: CNN_SEQ_TIMEOUT_EN adds a RUN+DRAIN watchdog of TIMEOUT_CYCLES.
module cnn_fc_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int FEAT_COUNT     = 6,
  parameter int OUT_COUNT      = 3,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            pe_enable,
  output logic                            fc_enable,
  output logic                            fc_pipe_reset,
  input  logic                            conv_valid,
  input  logic                            fc_out_valid,
  input  logic [DATA_WIDTH-1:0]           fc_out_data,
  output logic                            fc_out_ready,
  output logic [OUT_COUNT*DATA_WIDTH-1:0] result_data,
  output logic                            result_valid,
  input  logic                            result_ack,
  output logic                            busy,
  output logic                            error,
  output logic [15:0]                     frame_count
);

  localparam int FW = $clog2(FEAT_COUNT + 1);
  localparam int OW = $clog2(OUT_COUNT + 1);
  localparam int LW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FLUSH, RUN, DRAIN, HOLD
  } state_t;

  state_t state, state_nxt;

  logic [FW-1:0] feat_cnt;
  logic [OW-1:0] out_cnt;
  logic [LW-1:0] flush_cnt;

  logic act;
  logic stop;
  logic capture;
  logic last_out;
  logic last_feat;
  logic timeout;

`ifdef CNN_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign timeout = act && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (act) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign act  = (state == RUN) || (state == DRAIN);
  assign stop = abort || timeout;

  // Ready is registered from the next state, so it is already low
  // on the first HOLD cycle and no fourth word can slip in.
  assign capture  = act && !stop && fc_out_valid && fc_out_ready;
  assign last_out = capture && (out_cnt == OW'(OUT_COUNT - 1));
  assign last_feat = (state == RUN) && conv_valid &&
                     (feat_cnt == FW'(FEAT_COUNT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (abort)
          state_nxt = IDLE;
        else if (flush_cnt == LW'(FLUSH_CYCLES - 1))
          state_nxt = RUN;
      end
      RUN: begin
        if (stop)
          state_nxt = IDLE;
        else if (last_out)
          state_nxt = HOLD;
        else if (last_feat)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (stop)
          state_nxt = IDLE;
        else if (last_out)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (result_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pe_enable     <= 1'b0;
      fc_enable     <= 1'b0;
      fc_pipe_reset <= 1'b0;
      fc_out_ready  <= 1'b0;
      result_data   <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      frame_count   <= '0;
      feat_cnt      <= '0;
      out_cnt       <= '0;
      flush_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      result_valid <= (state_nxt == HOLD);
      fc_out_ready <= (state_nxt == RUN) ||
                      (state_nxt == DRAIN);
      // Enables follow the current state, one cycle behind it.
      pe_enable     <= (state == RUN);
      fc_enable     <= act;
      fc_pipe_reset <= (state == FLUSH) || timeout;

      if (state == IDLE && start) begin
        error     <= 1'b0;
        feat_cnt  <= '0;
        out_cnt   <= '0;
        flush_cnt <= '0;
      end

      if (state == FLUSH)
        flush_cnt <= flush_cnt + LW'(1);

      if (state == RUN && conv_valid && !stop)
        feat_cnt <= feat_cnt + FW'(1);

      if ((act || state == FLUSH) && abort)
        error <= 1'b1;
      if (state == DRAIN && conv_valid)
        error <= 1'b1;
      if (timeout)
        error <= 1'b1;

      if (capture) begin
        for (int k = 0; k < OUT_COUNT; k++) begin
          if (out_cnt == OW'(k))
            result_data[k*DATA_WIDTH +: DATA_WIDTH] <= fc_out_data;
        end
        out_cnt <= out_cnt + OW'(1);
      end

      if (last_out)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cnn_fc_sequencer.sv
// tb_cnn_fc_sequencer: directed bench for cnn_fc_sequencer.
// Linear steps; inputs driven 1ns after rising edge, outputs checked there.
module tb_cnn_fc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        pe_enable;
  logic        fc_enable;
  logic        fc_pipe_reset;
  logic        conv_valid;
  logic        fc_out_valid;
  logic [15:0] fc_out_data;
  logic        fc_out_ready;
  logic [47:0] result_data;
  logic        result_valid;
  logic        result_ack;
  logic        busy;
  logic        error;
  logic [15:0] frame_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cnn_fc_sequencer #(
    .DATA_WIDTH(16),
    .FEAT_COUNT(6),
    .OUT_COUNT(3),
    .FLUSH_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .pe_enable(pe_enable),
    .fc_enable(fc_enable),
    .fc_pipe_reset(fc_pipe_reset),
    .conv_valid(conv_valid),
    .fc_out_valid(fc_out_valid),
    .fc_out_data(fc_out_data),
    .fc_out_ready(fc_out_ready),
    .result_data(result_data),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .busy(busy),
    .error(error),
    .frame_count(frame_count)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_pe"}, 64'(pe_enable), 64'd0);
    chk({tag, "_fce"}, 64'(fc_enable), 64'd0);
    chk({tag, "_prst"}, 64'(fc_pipe_reset), 64'd0);
    chk({tag, "_rdy"}, 64'(fc_out_ready), 64'd0);
    chk({tag, "_rv"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(error), 64'd0);
    chk({tag, "_rd"}, 64'(result_data), 64'd0);
    chk({tag, "_fcnt"}, 64'(frame_count), 64'd0);
  endtask

  task automatic word(input logic [15:0] d);
    fc_out_valid = 1'b1;
    fc_out_data  = d;
    tick();
    fc_out_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    conv_valid = 1'b0;
    fc_out_valid = 1'b0;
    fc_out_data = '0;
    result_ack = 1'b0;
    tick(2);
    chk_idle_outs("rst");
    rst_n = 1'b1;
    tick();

    // Frame 1: flush timing, 6 features, 3 words in DRAIN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_prst_lag", 64'(fc_pipe_reset), 64'd0);
    tick();
    chk("t1_prst_on", 64'(fc_pipe_reset), 64'd1);
    tick(3);
    chk("t1_pe_pre", 64'(pe_enable), 64'd0);
    chk("t1_prst_last", 64'(fc_pipe_reset), 64'd1);
    tick();
    chk("t1_pe_rise", 64'(pe_enable), 64'd1);
    chk("t1_prst_off", 64'(fc_pipe_reset), 64'd0);
    chk("t1_rdy", 64'(fc_out_ready), 64'd1);
    conv_valid = 1'b1;
    tick(6);
    conv_valid = 1'b0;
    tick();
    chk("t1_drain_pe", 64'(pe_enable), 64'd0);
    chk("t1_drain_fce", 64'(fc_enable), 64'd1);
    word(16'h0100);
    word(16'hFF00);
    chk("t1_rv_pre", 64'(result_valid), 64'd0);
    word(16'h0010);
    chk("t1_rv", 64'(result_valid), 64'd1);
    chk("t1_rd", 64'(result_data), 64'h0010_FF00_0100);
    chk("t1_fcnt", 64'(frame_count), 64'd1);
    chk("t1_hold_rdy", 64'(fc_out_ready), 64'd0);
    tick();
    chk("t1_hold_fce", 64'(fc_enable), 64'd0);
    chk("t1_hold_rv", 64'(result_valid), 64'd1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("t1_ack_busy", 64'(busy), 64'd0);
    chk("t1_ack_rv", 64'(result_valid), 64'd0);

    // Frame 2: sparse words captured in RUN, extra word in HOLD
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    word(16'h1111);
    tick(2);
    word(16'h2222);
    tick(2);
    word(16'h3333);
    chk("t2_rv", 64'(result_valid), 64'd1);
    chk("t2_rd", 64'(result_data), 64'h3333_2222_1111);
    chk("t2_fcnt", 64'(frame_count), 64'd2);
    chk("t2_rdy", 64'(fc_out_ready), 64'd0);
    fc_out_valid = 1'b1;
    fc_out_data = 16'h4444;
    start = 1'b1;
    tick(2);
    fc_out_valid = 1'b0;
    chk("t2_rd_frozen", 64'(result_data), 64'h3333_2222_1111);
    chk("t2_start_ign", 64'(result_valid), 64'd1);
    chk("t2_fcnt_hold", 64'(frame_count), 64'd2);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("t2_ack_idle", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    chk("t2_resample", 64'(busy), 64'd1);

    // Frame 3: abort in RUN after 3 features
    tick(4);
    conv_valid = 1'b1;
    tick(3);
    conv_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_err", 64'(error), 64'd1);
    chk("t3_rv", 64'(result_valid), 64'd0);
    chk("t3_fcnt", 64'(frame_count), 64'd2);
    tick();
    chk("t3_pe_off", 64'(pe_enable), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_idle", 64'(busy), 64'd0);

    // Frame 4: 7th feature lands in DRAIN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_clr", 64'(error), 64'd0);
    tick(4);
    conv_valid = 1'b1;
    tick(6);
    chk("t4_err_6", 64'(error), 64'd0);
    tick();
    conv_valid = 1'b0;
    chk("t4_err_ovf", 64'(error), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    word(16'hAAAA);
    word(16'hBBBB);
    word(16'hCCCC);
    chk("t4_rv", 64'(result_valid), 64'd1);
    chk("t4_rd", 64'(result_data), 64'hCCCC_BBBB_AAAA);
    chk("t4_fcnt", 64'(frame_count), 64'd3);
    chk("t4_err_keep", 64'(error), 64'd1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // Frame 5: reset while in DRAIN
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    conv_valid = 1'b1;
    tick(6);
    conv_valid = 1'b0;
    word(16'h1234);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle_outs("t5");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart", 64'(busy), 64'd1);

    // Frame 6: stalled frame, watchdog or none
    tick(23);
    chk("t6_run", 64'(pe_enable), 64'd1);
`ifdef CNN_SEQ_TIMEOUT_EN
    tick();
    chk("t6_to_busy", 64'(busy), 64'd0);
    chk("t6_to_err", 64'(error), 64'd1);
    chk("t6_to_prst", 64'(fc_pipe_reset), 64'd1);
    tick();
    chk("t6_prst_pulse", 64'(fc_pipe_reset), 64'd0);
`else
    tick(1000);
    chk("t6_still_busy", 64'(busy), 64'd1);
    chk("t6_still_pe", 64'(pe_enable), 64'd1);
    chk("t6_no_err", 64'(error), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort", 64'(busy), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
